axis_fir_engine: RTL and testbench

//  Streaming FIR kernel directly downstream of the DMA controller's AXI-Stream master, and upstream of its slave input.

---
 rtl/axis_fir_pkg.sv | 31 +++
 rtl/fir_mac_unit.sv | 60 ++++++
 rtl/axis_fir_engine.sv | 172 +++++++++++++++++
 tb/tb_axis_fir_engine.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fir_pkg.sv
// axis_fir_pkg: shared state type, default sizes and arithmetic helpers
// for the streaming FIR engine (axis_fir_engine / fir_mac_unit).
package axis_fir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_COEF,
        WAIT_SMP,
        MAC,
        OUT
    } fir_state_t;

    localparam int NTAP_DEFAULT = 11;
    localparam int DW_DEFAULT   = 32;

    // Accumulator width: a full signed product plus guard bits for NTAP terms.
    function automatic int acc_width(input int ntap, input int dw);
        return 2 * dw + $clog2(ntap);
    endfunction

    // Largest positive dw-bit signed value (dw <= 64), as a 64-bit pattern.
    function automatic logic [63:0] sat_max(input int dw);
        return (64'd1 << (dw - 1)) - 64'd1;
    endfunction

    // Most negative dw-bit signed value, sign-extended to 64 bits.
    function automatic logic [63:0] sat_min(input int dw);
        return ~sat_max(dw);
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: registered signed multiply-accumulate used serially by the
// FIR engine. 'result' is the DW-bit view of the value being written into
// the accumulator this cycle, so the caller can register the final sum on
// the same edge that adds the last product.
// Build option: AXIS_FIR_SAT_EN clamps 'result' to the signed DW-bit range
// instead of wrapping.
module fir_mac_unit
    import axis_fir_pkg::*;
#(
    parameter int NTAP = NTAP_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 en,
    input  logic signed [DW-1:0] coef,
    input  logic signed [DW-1:0] sample,
    output logic        [DW-1:0] result
);

    localparam int AW = acc_width(NTAP, DW);

    logic signed [AW-1:0]   acc;
    logic signed [2*DW-1:0] prod;
    logic        [AW-1:0]   sum;

    assign prod = (2*DW)'(coef) * (2*DW)'(sample);
    assign sum  = (clear ? '0 : acc) + {{(AW-2*DW){prod[2*DW-1]}}, prod};

    // Accumulate one product per enabled cycle; 'clear' restarts from this product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

`ifdef AXIS_FIR_SAT_EN
    localparam logic [DW-1:0] SAT_HI = DW'(sat_max(DW));
    localparam logic [DW-1:0] SAT_LO = DW'(sat_min(DW));

    logic ovf;

    // The sum fits DW bits only if every bit above the result sign bit matches it.
    assign ovf = (sum[AW-1:DW-1] != {(AW-DW+1){sum[DW-1]}});

    // Clamp toward the sign of the full-precision sum when it does not fit.
    always_comb begin
        result = sum[DW-1:0];
        if (ovf) begin
            result = sum[AW-1] ? SAT_LO : SAT_HI;
        end
    end
`else
    assign result = sum[DW-1:0];
`endif

endmodule

// File: rtl/axis_fir_engine.sv
// axis_fir_engine: frame-based streaming FIR. A frame is NTAP coefficient
// beats followed by samples up to tlast; each sample yields one result,
// computed serially on one shared MAC over NTAP cycles.
// Build option: AXIS_FIR_SAT_EN (passed through to fir_mac_unit) saturates
// results instead of wrapping them.
module axis_fir_engine
    import axis_fir_pkg::*;
#(
    parameter int NTAP = NTAP_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ss_tvalid,
    input  logic [DW-1:0] ss_tdata,
    input  logic          ss_tlast,
    output logic          ss_tready,
    output logic          sm_tvalid,
    output logic [DW-1:0] sm_tdata,
    output logic          sm_tlast,
    input  logic          sm_tready,
    input  logic          ap_start,
    output logic          ap_idle,
    output logic          ap_done,
    output logic          err
);

    localparam int             IW       = $clog2(NTAP);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NTAP - 1);

    fir_state_t           state, state_next;
    logic signed [DW-1:0] coef [NTAP];
    logic signed [DW-1:0] x    [NTAP];
    logic [IW-1:0]        idx;
    logic                 idx_last;
    logic                 last_smp;
    logic [DW-1:0]        out_data;
    logic [DW-1:0]        mac_result;
    logic                 done_next;

    assign idx_last = (idx == LAST_IDX);
    assign sm_tdata = out_data;
    assign sm_tlast = sm_tvalid && last_smp;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, stream handshakes, idle flag and frame-end detection.
    always_comb begin
        state_next = state;
        ss_tready  = 1'b0;
        sm_tvalid  = 1'b0;
        ap_idle    = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    state_next = LOAD_COEF;
                end
            end
            LOAD_COEF: begin
                ss_tready = 1'b1;
                if (ss_tvalid) begin
                    if (ss_tlast) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else if (idx_last) begin
                        state_next = WAIT_SMP;
                    end
                end
            end
            WAIT_SMP: begin
                ss_tready = 1'b1;
                if (ss_tvalid) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                if (idx_last) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                sm_tvalid = 1'b1;
                if (sm_tready) begin
                    if (last_smp) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = WAIT_SMP;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Coefficient/sample registers, tap counter, result register and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAP; i++) begin
                coef[i] <= '0;
                x[i]    <= '0;
            end
            idx      <= '0;
            last_smp <= 1'b0;
            out_data <= '0;
            ap_done  <= 1'b0;
            err      <= 1'b0;
        end else begin
            ap_done <= done_next;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        for (int i = 0; i < NTAP; i++) begin
                            x[i] <= '0;
                        end
                        idx <= '0;
                        err <= 1'b0;
                    end
                end
                LOAD_COEF: begin
                    if (ss_tvalid) begin
                        coef[idx] <= ss_tdata;
                        if (ss_tlast) begin
                            err <= 1'b1;
                        end
                        idx <= (idx_last || ss_tlast) ? '0 : idx + 1'b1;
                    end
                end
                WAIT_SMP: begin
                    if (ss_tvalid) begin
                        x[0] <= ss_tdata;
                        for (int i = 1; i < NTAP; i++) begin
                            x[i] <= x[i-1];
                        end
                        last_smp <= ss_tlast;
                        idx      <= '0;
                    end
                end
                MAC: begin
                    idx <= idx_last ? '0 : idx + 1'b1;
                    if (idx_last) begin
                        out_data <= mac_result;
                    end
                end
                default: ;
            endcase
        end
    end

    fir_mac_unit #(
        .NTAP (NTAP),
        .DW   (DW)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  ((state == MAC) && (idx == '0)),
        .en     (state == MAC),
        .coef   (coef[idx]),
        .sample (x[idx]),
        .result (mac_result)
    );

endmodule

// File: tb/tb_axis_fir_engine.sv
// tb_axis_fir_engine: self-checking bench for axis_fir_engine. Results are
// compared against a direct convolution of each frame's coefficients and
// samples (zero history at frame start).
module tb_axis_fir_engine;

    localparam int NTAP = 11;
    localparam int DW   = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ss_tvalid;
    logic [DW-1:0] ss_tdata;
    logic          ss_tlast;
    logic          ss_tready;
    logic          sm_tvalid;
    logic [DW-1:0] sm_tdata;
    logic          sm_tlast;
    logic          sm_tready;
    logic          ap_start;
    logic          ap_idle;
    logic          ap_done;
    logic          err;

    int checks     = 0;
    int errors     = 0;
    int done_count = 0;

    int            frame_coef [NTAP];
    int            frame_smp  [$];
    logic [DW-1:0] got_data   [$];
    logic          got_last   [$];
    bit            bp_mode;
    bit            inject_start;
    bit            skip_start;

    axis_fir_engine #(.NTAP(NTAP), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ss_tvalid (ss_tvalid),
        .ss_tdata  (ss_tdata),
        .ss_tlast  (ss_tlast),
        .ss_tready (ss_tready),
        .sm_tvalid (sm_tvalid),
        .sm_tdata  (sm_tdata),
        .sm_tlast  (sm_tlast),
        .sm_tready (sm_tready),
        .ap_start  (ap_start),
        .ap_idle   (ap_idle),
        .ap_done   (ap_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Count ap_done pulses as seen at each rising edge.
    always @(posedge clk) begin
        if (ap_done === 1'b1) done_count++;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog expired at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Reference: direct convolution sum_i coef[i]*s[n-i], zero before the frame.
    function automatic logic [DW-1:0] model_out(input int n);
        logic signed [127:0] acc;
        logic signed [127:0] term;
        acc = '0;
        for (int i = 0; i < NTAP; i++) begin
            if (n - i >= 0) begin
                term = longint'(frame_coef[i]) * longint'(frame_smp[n-i]);
                acc  = acc + term;
            end
        end
`ifdef AXIS_FIR_SAT_EN
        if (acc > 128'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        if (acc < -128'sh8000_0000) return 32'h8000_0000;
`endif
        return acc[DW-1:0];
    endfunction

    function automatic int rnd_val(input bit full);
        if (full) return int'($urandom);
        return int'($urandom_range(0, 200)) - 100;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int n;
        n = 0;
        ss_tvalid = 1'b1;
        ss_tdata  = d;
        ss_tlast  = l;
        while (ss_tready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout ss_tready=%b required 1 within 200 cycles", ss_tready);
        end else begin
            step();
        end
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
    endtask

    task automatic recv_result(output logic [DW-1:0] d, output logic l, output int waited);
        waited = 0;
        d = '0;
        l = 1'b0;
        forever begin
            sm_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sm_tvalid === 1'b1 && sm_tready) begin
                d = sm_tdata;
                l = sm_tlast;
                step();
                sm_tready = 1'b0;
                return;
            end
            if (waited >= 300) begin
                checks++;
                errors++;
                $display("[TB] FAIL recv_timeout sm_tvalid=%b required 1 within 300 cycles", sm_tvalid);
                sm_tready = 1'b0;
                return;
            end
            step();
            waited++;
        end
    endtask

    task automatic run_frame();
        logic [DW-1:0] d;
        logic          l;
        int            w;
        got_data.delete();
        got_last.delete();
        if (!skip_start) pulse_start();
        for (int k = 0; k < NTAP; k++) begin
            if (inject_start && k == 5) pulse_start();
            send_beat(frame_coef[k], 1'b0);
        end
        foreach (frame_smp[n]) begin
            send_beat(frame_smp[n], n == frame_smp.size() - 1);
            if (inject_start && n == 0) pulse_start();
            recv_result(d, l, w);
            got_data.push_back(d);
            got_last.push_back(l);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (ap_idle !== 1'b1)   begin errors++; $display("[TB] FAIL reset_ap_idle got %b expected 1", ap_idle); end
        checks++; if (ss_tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ss_tready got %b expected 0", ss_tready); end
        checks++; if (sm_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_sm_tvalid got %b expected 0", sm_tvalid); end
        checks++; if (sm_tdata !== '0)    begin errors++; $display("[TB] FAIL reset_sm_tdata got %h expected 0", sm_tdata); end
        checks++; if (sm_tlast !== 1'b0)  begin errors++; $display("[TB] FAIL reset_sm_tlast got %b expected 0", sm_tlast); end
        checks++; if (ap_done !== 1'b0)   begin errors++; $display("[TB] FAIL reset_ap_done got %b expected 0", ap_done); end
        checks++; if (err !== 1'b0)       begin errors++; $display("[TB] FAIL reset_err got %b expected 0", err); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_identity();
        logic [DW-1:0] exp_d [3];
        int base;
        exp_d = '{32'd5, 32'hFFFF_FFFD, 32'd7};
        frame_coef = '{default: 0};
        frame_coef[0] = 1;
        frame_smp = '{5, -3, 7};
        bp_mode = 1'b0; inject_start = 1'b0; skip_start = 1'b0;
        base = done_count;
        run_frame();
        checks++; if (ap_done !== 1'b1) begin errors++; $display("[TB] FAIL identity_done got %b expected 1", ap_done); end
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("[TB] FAIL identity_idle got %b expected 1", ap_idle); end
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (got_data[n] !== exp_d[n]) begin errors++; $display("[TB] FAIL identity_data[%0d] got %h expected %h", n, got_data[n], exp_d[n]); end
            checks++;
            if (got_last[n] !== (n == 2)) begin errors++; $display("[TB] FAIL identity_last[%0d] got %b expected %b", n, got_last[n], n == 2); end
        end
        step();
        checks++; if (ap_done !== 1'b0) begin errors++; $display("[TB] FAIL identity_done_width got %b expected 0", ap_done); end
        step();
        checks++; if (done_count - base != 1) begin errors++; $display("[TB] FAIL identity_done_count got %0d expected 1", done_count - base); end
    endtask

    task automatic test_impulse();
        for (int k = 0; k < NTAP; k++) frame_coef[k] = k + 1;
        frame_smp.delete();
        frame_smp.push_back(1);
        repeat (10) frame_smp.push_back(0);
        bp_mode = 1'b1; inject_start = 1'b0; skip_start = 1'b0;
        run_frame();
        foreach (frame_smp[n]) begin
            checks++;
            if (got_data[n] !== DW'(n + 1)) begin errors++; $display("[TB] FAIL impulse_data[%0d] got %h expected %h", n, got_data[n], DW'(n + 1)); end
            checks++;
            if (got_last[n] !== (n == 10)) begin errors++; $display("[TB] FAIL impulse_last[%0d] got %b expected %b", n, got_last[n], n == 10); end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d0, d;
        logic          l;
        int            w;
        bit            stable;
        for (int k = 0; k < NTAP; k++) frame_coef[k] = rnd_val(1'b0);
        frame_smp = '{rnd_val(1'b0), rnd_val(1'b0)};
        bp_mode = 1'b0;
        pulse_start();
        for (int k = 0; k < NTAP; k++) send_beat(frame_coef[k], 1'b0);
        sm_tready = 1'b0;
        send_beat(frame_smp[0], 1'b0);
        w = 0;
        while (sm_tvalid !== 1'b1 && w < 50) begin step(); w++; end
        checks++; if (w != NTAP) begin errors++; $display("[TB] FAIL bp_latency got %0d cycles expected %0d", w, NTAP); end
        d0 = sm_tdata;
        checks++; if (d0 !== model_out(0)) begin errors++; $display("[TB] FAIL bp_data0 got %h expected %h", d0, model_out(0)); end
        ss_tvalid = 1'b1;
        ss_tdata  = frame_smp[1];
        ss_tlast  = 1'b1;
        stable = 1'b1;
        repeat (20) begin
            step();
            if (sm_tvalid !== 1'b1 || sm_tdata !== d0 || ss_tready !== 1'b0) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("[TB] FAIL bp_hold got unstable output or ss_tready high expected stable"); end
        sm_tready = 1'b1;
        step();
        sm_tready = 1'b0;
        step();
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
        recv_result(d, l, w);
        checks++; if (d !== model_out(1)) begin errors++; $display("[TB] FAIL bp_data1 got %h expected %h", d, model_out(1)); end
        checks++; if (l !== 1'b1) begin errors++; $display("[TB] FAIL bp_last1 got %b expected 1", l); end
        checks++; if (w != NTAP) begin errors++; $display("[TB] FAIL bp_latency1 got %0d cycles expected %0d", w, NTAP); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_v;
`ifdef AXIS_FIR_SAT_EN
        exp_v = 32'h7FFF_FFFF;
`else
        exp_v = 32'hFFFF_FFFE;
`endif
        frame_coef = '{default: 0};
        frame_coef[0] = 32'h7FFF_FFFF;
        frame_smp = '{2};
        bp_mode = 1'b0; inject_start = 1'b0; skip_start = 1'b0;
        run_frame();
        checks++; if (got_data[0] !== exp_v) begin errors++; $display("[TB] FAIL overflow_data got %h expected %h", got_data[0], exp_v); end
    endtask

    task automatic test_early_tlast();
        pulse_start();
        for (int k = 0; k < 4; k++) send_beat(rnd_val(1'b1), 1'b0);
        send_beat(rnd_val(1'b1), 1'b1);
        checks++; if (err !== 1'b1)     begin errors++; $display("[TB] FAIL early_err got %b expected 1", err); end
        checks++; if (ap_done !== 1'b1) begin errors++; $display("[TB] FAIL early_done got %b expected 1", ap_done); end
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("[TB] FAIL early_idle got %b expected 1", ap_idle); end
        step();
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL early_err_sticky got %b expected 1", err); end
        pulse_start();
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL early_err_clear got %b expected 0", err); end
        for (int k = 0; k < NTAP; k++) frame_coef[k] = rnd_val(1'b0);
        frame_smp = '{rnd_val(1'b0), rnd_val(1'b0)};
        bp_mode = 1'b0; inject_start = 1'b0; skip_start = 1'b1;
        run_frame();
        skip_start = 1'b0;
        foreach (frame_smp[n]) begin
            checks++;
            if (got_data[n] !== model_out(n)) begin errors++; $display("[TB] FAIL early_next_data[%0d] got %h expected %h", n, got_data[n], model_out(n)); end
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        for (int k = 0; k < NTAP; k++) send_beat(rnd_val(1'b1), 1'b0);
        send_beat(rnd_val(1'b1), 1'b0);
        repeat (3) step();
        checks++; if (ss_tready !== 1'b0 || ap_idle !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy got ss_tready=%b ap_idle=%b expected 0 0", ss_tready, ap_idle); end
        pulse_start();
        rst_n = 1'b0;
        repeat (2) step();
        checks++; if (ap_idle !== 1'b1 || sm_tvalid !== 1'b0 || sm_tdata !== '0 || err !== 1'b0)
            begin errors++; $display("[TB] FAIL mid_reset got idle=%b tvalid=%b tdata=%h err=%b expected 1 0 0 0", ap_idle, sm_tvalid, sm_tdata, err); end
        rst_n = 1'b1;
        step();
        for (int k = 0; k < NTAP; k++) frame_coef[k] = rnd_val(1'b0);
        frame_smp.delete();
        repeat (6) frame_smp.push_back(rnd_val(1'b0));
        bp_mode = 1'b1; inject_start = 1'b1; skip_start = 1'b0;
        run_frame();
        inject_start = 1'b0;
        foreach (frame_smp[n]) begin
            checks++;
            if (got_data[n] !== model_out(n)) begin errors++; $display("[TB] FAIL mid_new_data[%0d] got %h expected %h", n, got_data[n], model_out(n)); end
        end
    endtask

    task automatic test_random();
        int len;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < NTAP; k++) frame_coef[k] = rnd_val(f == 2);
            len = $urandom_range(3, 8);
            frame_smp.delete();
            for (int n = 0; n < len; n++) frame_smp.push_back(rnd_val(f != 0));
            bp_mode = 1'b1; inject_start = (f == 1); skip_start = 1'b0;
            run_frame();
            foreach (frame_smp[n]) begin
                checks++;
                if (got_data[n] !== model_out(n)) begin errors++; $display("[TB] FAIL random%0d_data[%0d] got %h expected %h", f, n, got_data[n], model_out(n)); end
                checks++;
                if (got_last[n] !== (n == len - 1)) begin errors++; $display("[TB] FAIL random%0d_last[%0d] got %b expected %b", f, n, got_last[n], n == len - 1); end
            end
        end
        inject_start = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        ss_tvalid    = 1'b0;
        ss_tdata     = '0;
        ss_tlast     = 1'b0;
        sm_tready    = 1'b0;
        ap_start     = 1'b0;
        bp_mode      = 1'b0;
        inject_start = 1'b0;
        skip_start   = 1'b0;
        test_reset();
        test_identity();
        test_impulse();
        test_backpressure();
        test_overflow();
        test_early_tlast();
        test_reset_mid();
        test_random();
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
